matmul_arbiter: RTL and testbench
=================================

Name: matmul_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the shared combinational matrix multiply unit (up to 5x5, 8-bit elements).
- Grants the unit to one requester at a time and latches that requester's dimensions and operands into registers that drive the unit.
- Waits a fixed settle time, then captures the product into result registers.
- Returns a done pulse, plus an error pulse if the dimensions were rejected, to the requester that owned the grant.

Parameters:
SETTLE_CYCLES, 2, cycles the unit's inputs are held stable before capture; legal range 1..15.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  2  req[i] = requester i wants the unit; held high until gnt[i]
dims0  in  12  requester 0 {a_m,a_n,b_m,b_n}, 3 bits each, a_m in [11:9]
data0  in  400  requester 0 operands: A in [199:0], B in [399:200]; element (r,c) at bits (r*5+c)*8 +: 8
dims1  in  12  requester 1 dims, same packing as dims0
data1  in  400  requester 1 operands, same packing as data0
gnt  out  2  one-hot, 1-cycle grant pulse
busy  out  1  high while an operation is in flight
mmu_dims  out  12  latched {a_m,a_n,b_m,b_n} driven to the unit
mmu_matrices_in  out  400  latched operands driven to the unit
mmu_c_m  in  3  result rows from the unit
mmu_c_n  in  3  result columns from the unit
mmu_matrices_out  in  400  result from the unit; element (r,c) at bits (r*5+c)*8 +: 8
mmu_valid  in  1  unit accepted the dimensions
res_c_m  out  3  captured result rows
res_c_n  out  3  captured result columns
result  out  400  captured product
done  out  2  one-hot, 1-cycle completion pulse to the owning requester
err  out  2  one-hot, 1-cycle pulse coincident with done when mmu_valid was 0

Behaviour:
- States: IDLE, RUN. Internal registers:
  - owner (1 bit)
  - last (1 bit, the last-served requester)
  - cnt (4 bits)
- Reset:
  - state=IDLE, last=1 (so requester 0 wins first), cnt=0, owner=0.
  - All outputs 0: gnt, busy, done, err, mmu_dims, mmu_matrices_in, result, res_c_m, res_c_n.
  - Reset mid-RUN aborts the operation: no done or err is emitted.
- IDLE, req==0: stay in IDLE. Outputs hold their values except gnt, done and err, which are 0.
- IDLE, req!=0, at a clock edge:
  - Select requester: if only one is requesting, that one; if both, the one != last.
  - Latch that requester's dims/data into mmu_dims/mmu_matrices_in.
  - owner=sel, gnt[sel]=1 for the next cycle only, busy=1, cnt=SETTLE_CYCLES, go to RUN.
- RUN: cnt decrements each edge. At the edge where cnt==1:
  - Capture mmu_matrices_out->result, mmu_c_m->res_c_m, mmu_c_n->res_c_n.
  - done[owner]=1 and err[owner]=~mmu_valid, each for exactly one cycle.
  - last=owner, busy=0, go to IDLE.
- RUN ignores req; mmu_dims/mmu_matrices_in stay constant throughout RUN.
- Timing:
  - req sampled at edge E: gnt visible in cycle E..E+1; done visible in cycle E+SETTLE_CYCLES..E+SETTLE_CYCLES+1.
  - Issue rate: one operation per SETTLE_CYCLES+1 cycles.
- Back-to-back: a new grant may be taken at the edge that ends the done cycle. A requester still holding req after done is treated as a new request.
- Requester protocol:
  - If req is dropped before gnt, no grant is issued.
  - dims/data only need to be valid in the cycle req is sampled high.
- After an error capture, result/res_c_m/res_c_n take the unit's outputs (zeros).
- result/res_c_m/res_c_n hold until the next capture. mmu_dims/mmu_matrices_in hold after capture until the next grant.
- gnt, done and err are never multi-hot.

Test Plan:
- Reset, then single op: req=01, dims0=2,2,2,2, A=[[1,2],[3,4]], B=identity, SETTLE_CYCLES=2 -> gnt=01 one cycle; done=01 two cycles after the gnt edge; result bytes 0,1,5,6 = 1,2,3,4; res_c_m=res_c_n=2; err=00.
- Simultaneous requests: req=11 immediately after reset -> grant order 0,1,0,1 while both stay high; done pulses alternate 01,10; each cycle of operation is 3 cycles long.
- Dimension error: req=10, dims1=2,3,2,2 (a_n!=b_m) -> done=10 and err=10 in the same cycle; result all zero.
- Request during RUN: req1 rises in the middle of requester 0's operation -> no gnt until requester 0's done cycle; gnt=10 at the next edge.
- Reset mid-RUN, asserted in the first RUN cycle -> no done/err; all outputs 0; next req=11 grants requester 0.
- Max size: 5x5 all 0x10 times 5x5 all 0x10 -> each element 5*256 mod 256 = 0x00; then all 0x01 times all 0x01 -> each element 0x05.

Source files
------------

// File: rtl/matmul_arbiter.sv
// rtl/matmul_arbiter.sv - two-port round-robin arbiter and sequencer for a shared combinational matrix multiply unit
module matmul_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [11:0]  dims0,
    input  logic [399:0] data0,
    input  logic [11:0]  dims1,
    input  logic [399:0] data1,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [11:0]  mmu_dims,
    output logic [399:0] mmu_matrices_in,
    input  logic [2:0]   mmu_c_m,
    input  logic [2:0]   mmu_c_n,
    input  logic [399:0] mmu_matrices_out,
    input  logic         mmu_valid,
    output logic [2:0]   res_c_m,
    output logic [2:0]   res_c_n,
    output logic [399:0] result,
    output logic [1:0]   done,
    output logic [1:0]   err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t     state;
    logic       owner;
    logic       last;
    logic [3:0] cnt;
    logic       sel;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        sel = 1'b0;
        if (req == 2'b11) begin
            sel = ~last;
        end else if (req[1]) begin
            sel = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= 1'b0;
            last            <= 1'b1;
            cnt             <= 4'd0;
            gnt             <= 2'b00;
            busy            <= 1'b0;
            done            <= 2'b00;
            err             <= 2'b00;
            mmu_dims        <= '0;
            mmu_matrices_in <= '0;
            result          <= '0;
            res_c_m         <= '0;
            res_c_n         <= '0;
        end else begin
            gnt  <= 2'b00;
            done <= 2'b00;
            err  <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner           <= sel;
                        gnt             <= sel ? 2'b10 : 2'b01;
                        busy            <= 1'b1;
                        cnt             <= SETTLE;
                        mmu_dims        <= sel ? dims1 : dims0;
                        mmu_matrices_in <= sel ? data1 : data0;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        result  <= mmu_matrices_out;
                        res_c_m <= mmu_c_m;
                        res_c_n <= mmu_c_n;
                        done    <= owner ? 2'b10 : 2'b01;
                        err     <= mmu_valid ? 2'b00 : (owner ? 2'b10 : 2'b01);
                        last    <= owner;
                        busy    <= 1'b0;
                        cnt     <= 4'd0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_arbiter.sv
// tb/tb_matmul_arbiter.sv - self-checking bench for matmul_arbiter with a bench-side multiply unit
module tb_matmul_arbiter;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req = 2'b00;
    logic [11:0]  dims0 = '0, dims1 = '0;
    logic [399:0] data0 = '0, data1 = '0;
    logic [1:0]   gnt, done, err;
    logic         busy;
    logic [11:0]  mmu_dims;
    logic [399:0] mmu_matrices_in, mmu_matrices_out, result;
    logic [2:0]   mmu_c_m, mmu_c_n, res_c_m, res_c_n;
    logic         mmu_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    matmul_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .req(req),
        .dims0(dims0), .data0(data0), .dims1(dims1), .data1(data1),
        .gnt(gnt), .busy(busy), .mmu_dims(mmu_dims), .mmu_matrices_in(mmu_matrices_in),
        .mmu_c_m(mmu_c_m), .mmu_c_n(mmu_c_n), .mmu_matrices_out(mmu_matrices_out),
        .mmu_valid(mmu_valid), .res_c_m(res_c_m), .res_c_n(res_c_n), .result(result),
        .done(done), .err(err)
    );

    // Reference matrix multiply: rejects shapes outside 1..5 or with a_n != b_m.
    function automatic void unit(input logic [11:0] d, input logic [399:0] m,
                                 output logic [399:0] o, output logic [2:0] cm,
                                 output logic [2:0] cn, output logic v);
        int am, an, bm, bn;
        logic [7:0] acc;
        am = int'(d[11:9]); an = int'(d[8:6]); bm = int'(d[5:3]); bn = int'(d[2:0]);
        o = '0; cm = 3'd0; cn = 3'd0;
        v = (an == bm) && am >= 1 && am <= 5 && an >= 1 && an <= 5 && bn >= 1 && bn <= 5;
        if (v) begin
            cm = 3'(am); cn = 3'(bn);
            for (int r = 0; r < am; r++)
                for (int c = 0; c < bn; c++) begin
                    acc = 8'd0;
                    for (int k = 0; k < an; k++)
                        acc = acc + m[(r*5+k)*8 +: 8] * m[200+(k*5+c)*8 +: 8];
                    o[(r*5+c)*8 +: 8] = acc;
                end
        end
    endfunction

    always_comb unit(mmu_dims, mmu_matrices_in, mmu_matrices_out, mmu_c_m, mmu_c_n, mmu_valid);

    task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: an operation started at edge m_start completes at edge m_start+S.
    logic         m_active = 1'b0, m_owner = 1'b0, m_last = 1'b1;
    int           m_start = 0;
    logic [1:0]   e_gnt = '0, e_done = '0, e_err = '0;
    logic         e_busy = 1'b0;
    logic [11:0]  e_dims = '0;
    logic [399:0] e_mat = '0, e_result = '0;
    logic [2:0]   e_cm = '0, e_cn = '0;

    always @(posedge clk) begin
        logic [399:0] o;
        logic [2:0]   cm, cn;
        logic         v;
        cyc++;
        if (reset) begin
            m_active = 1'b0; m_last = 1'b1; m_owner = 1'b0;
            e_gnt = '0; e_done = '0; e_err = '0; e_busy = 1'b0;
            e_dims = '0; e_mat = '0; e_result = '0; e_cm = '0; e_cn = '0;
        end else begin
            e_gnt = '0; e_done = '0; e_err = '0;
            if (m_active) begin
                if (cyc == m_start + S) begin
                    unit(e_dims, e_mat, o, cm, cn, v);
                    e_result = o; e_cm = cm; e_cn = cn;
                    e_done[m_owner] = 1'b1;
                    e_err[m_owner] = ~v;
                    e_busy = 1'b0; m_active = 1'b0; m_last = m_owner;
                end
            end else if (req != 2'b00) begin
                m_owner = (req == 2'b11) ? ~m_last : req[1];
                e_dims = m_owner ? dims1 : dims0;
                e_mat = m_owner ? data1 : data0;
                e_gnt[m_owner] = 1'b1;
                e_busy = 1'b1; m_active = 1'b1; m_start = cyc;
            end
        end
    end

    always @(negedge clk) begin
        check("gnt", gnt, e_gnt);
        check("done", done, e_done);
        check("err", err, e_err);
        check("busy", busy, e_busy);
        check("mmu_dims", mmu_dims, e_dims);
        check("mmu_matrices_in", mmu_matrices_in, e_mat);
        check("result", result, e_result);
        check("res_c_m", res_c_m, e_cm);
        check("res_c_n", res_c_n, e_cn);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_gnt(input int who, output int gc);
        int k;
        gc = -1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt[who]) begin
                gc = cyc;
                break;
            end
        end
        if (k == 20) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done(output logic [1:0] d, output logic [1:0] e, output int dc);
        int k;
        d = '0; e = '0; dc = -1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                d = done; e = err; dc = cyc;
                break;
            end
        end
        if (k == 20) check("done_timeout", 0, 1);
    endtask

    task automatic do_op(input int who, input logic [11:0] d, input logic [399:0] m,
                         output logic [1:0] dn, output logic [1:0] er, output int lat);
        int gc, dc;
        @(negedge clk);
        if (who == 0) begin dims0 = d; data0 = m; req = 2'b01; end
        else begin dims1 = d; data1 = m; req = 2'b10; end
        wait_gnt(who, gc);
        req = 2'b00;
        wait_done(dn, er, dc);
        lat = dc - gc;
    endtask

    initial begin
        logic [399:0] m, exp_r;
        logic [1:0]   dn, er;
        int           lat, g0, g1;
        logic [1:0]   gv[$], dv[$];
        int           gcy[$];

        do_reset();
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_result", result, 0);

        // 2x2 [[1,2],[3,4]] times identity
        m = '0;
        m[0 +: 8] = 8'd1; m[8 +: 8] = 8'd2; m[40 +: 8] = 8'd3; m[48 +: 8] = 8'd4;
        m[200 +: 8] = 8'd1; m[248 +: 8] = 8'd1;
        do_op(0, {3'd2, 3'd2, 3'd2, 3'd2}, m, dn, er, lat);
        exp_r = '0;
        exp_r[0 +: 8] = 8'd1; exp_r[8 +: 8] = 8'd2; exp_r[40 +: 8] = 8'd3; exp_r[48 +: 8] = 8'd4;
        check("single_done", dn, 2'b01);
        check("single_err", er, 2'b00);
        check("single_latency", lat, S);
        @(negedge clk);
        check("single_result", result, exp_r);
        check("single_cm", res_c_m, 3'd2);
        check("single_cn", res_c_n, 3'd2);

        // a_n != b_m is rejected
        do_op(1, {3'd2, 3'd3, 3'd2, 3'd2}, m, dn, er, lat);
        check("dimerr_done", dn, 2'b10);
        check("dimerr_err", er, 2'b10);
        @(negedge clk);
        check("dimerr_result", result, 0);

        // requester 1 arrives while requester 0 is running
        @(negedge clk);
        dims0 = {3'd2, 3'd2, 3'd2, 3'd2}; data0 = m; req = 2'b01;
        wait_gnt(0, g0);
        dims1 = {3'd1, 3'd2, 3'd2, 3'd1}; data1 = m; req = 2'b10;
        wait_gnt(1, g1);
        req = 2'b00;
        check("during_run_gap", g1 - g0, S + 1);
        wait_done(dn, er, lat);
        check("during_run_done", dn, 2'b10);

        // both requesting straight out of reset
        do_reset();
        dims0 = {3'd1, 3'd1, 3'd1, 3'd1}; dims1 = {3'd1, 3'd1, 3'd1, 3'd1};
        data0 = m; data1 = m; req = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin gv.push_back(gnt); gcy.push_back(cyc); end
            if (done != 2'b00) dv.push_back(done);
        end
        req = 2'b00;
        check("rr_grant_count", gv.size(), 4);
        check("rr_done_count", dv.size(), 4);
        if (gv.size() == 4 && dv.size() == 4) begin
            check("rr_g0", gv[0], 2'b01); check("rr_g1", gv[1], 2'b10);
            check("rr_g2", gv[2], 2'b01); check("rr_g3", gv[3], 2'b10);
            check("rr_d0", dv[0], 2'b01); check("rr_d1", dv[1], 2'b10);
            check("rr_spacing", gcy[3] - gcy[0], 3 * (S + 1));
        end
        repeat (5) @(negedge clk);

        // reset in the first RUN cycle aborts the operation
        dims0 = {3'd2, 3'd2, 3'd2, 3'd2}; req = 2'b01;
        wait_gnt(0, g0);
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_dims", mmu_dims, 0);
        reset = 1'b0; req = 2'b11;
        @(negedge clk);
        check("abort_regrant", gnt, 2'b01);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done == 2'b10) check("abort_spurious_done", done, 2'b01);
        end

        // 5x5 extremes
        do_op(0, {3'd5, 3'd5, 3'd5, 3'd5}, {50{8'h10}}, dn, er, lat);
        @(negedge clk);
        check("max_wrap_result", result, 0);
        check("max_cm", res_c_m, 3'd5);
        check("max_err", er, 2'b00);
        do_op(1, {3'd5, 3'd5, 3'd5, 3'd5}, {50{8'h01}}, dn, er, lat);
        @(negedge clk);
        exp_r = {200'b0, {25{8'h05}}};
        check("max_ones_result", result, exp_r);
        check("max_cn", res_c_n, 3'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
